// File: rtl/rv_decode_pkg.sv
// Shared encodings and types for the RV decode stage.
package rv_decode_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD_SUB = 3'h0;
    localparam logic [2:0] F3_SLL     = 3'h1;
    localparam logic [2:0] F3_SLT     = 3'h2;
    localparam logic [2:0] F3_SLTU    = 3'h3;
    localparam logic [2:0] F3_XOR     = 3'h4;
    localparam logic [2:0] F3_SRL_SRA = 3'h5;
    localparam logic [2:0] F3_OR      = 3'h6;
    localparam logic [2:0] F3_AND     = 3'h7;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // OP_LD only decodes when XLEN=64.
    typedef enum logic [5:0] {
        OP_ADD = 6'd0, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_JAL, OP_JALR, OP_LUI, OP_AUIPC,
        OP_MUL = 6'd37, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
        OP_LD = 6'd45,
        OP_ILLEGAL = 6'd63
    } op_e;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    // Decoded record minus the XLEN-wide immediate, which travels beside it.
    typedef struct packed {
        op_e        op;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rd_we;
        logic       rs1_re;
        logic       rs2_re;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/rv_decode_comb.sv
// Pure combinational instruction decoder: raw word -> decoded record + immediate.
module rv_decode_comb
    import rv_decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int EN_M = 0
) (
    input  logic [31:0]     instr,
    output dec_t            dec,
    output logic [XLEN-1:0] imm
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        shift_lo_ok;
    logic        shift_ar_ok;
    op_e         op;
    logic        ok;
    logic        use_rd;
    logic        use_rs1;
    logic        use_rs2;
    logic [31:0] imm32;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // On RV64 bit 25 belongs to shamt, so only funct6 is checked.
    assign shift_lo_ok = (XLEN == 64) ? (instr[31:26] == 6'b000000) : (funct7 == F7_BASE);
    assign shift_ar_ok = (XLEN == 64) ? (instr[31:26] == 6'b010000) : (funct7 == F7_ALT);

    // Opcode/funct decode with exact compares; anything unmatched stays illegal.
    always_comb begin
        op      = OP_ILLEGAL;
        ok      = 1'b0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        imm32   = '0;
        case (opcode)
            OPC_OP: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                if (funct7 == F7_BASE) begin
                    ok = 1'b1;
                    case (funct3)
                        F3_ADD_SUB: op = OP_ADD;
                        F3_SLL:     op = OP_SLL;
                        F3_SLT:     op = OP_SLT;
                        F3_SLTU:    op = OP_SLTU;
                        F3_XOR:     op = OP_XOR;
                        F3_SRL_SRA: op = OP_SRL;
                        F3_OR:      op = OP_OR;
                        default:    op = OP_AND;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == F3_ADD_SUB) begin
                        ok = 1'b1;
                        op = OP_SUB;
                    end else if (funct3 == F3_SRL_SRA) begin
                        ok = 1'b1;
                        op = OP_SRA;
                    end
                end else if (funct7 == F7_MULDIV && EN_M != 0) begin
                    ok = 1'b1;
                    op = op_e'(6'(OP_MUL) + {3'b000, funct3});
                end
            end
            OPC_OP_IMM: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                imm32   = {{20{instr[31]}}, instr[31:20]};
                case (funct3)
                    F3_ADD_SUB: begin ok = 1'b1; op = OP_ADDI;  end
                    F3_SLT:     begin ok = 1'b1; op = OP_SLTI;  end
                    F3_SLTU:    begin ok = 1'b1; op = OP_SLTIU; end
                    F3_XOR:     begin ok = 1'b1; op = OP_XORI;  end
                    F3_OR:      begin ok = 1'b1; op = OP_ORI;   end
                    F3_AND:     begin ok = 1'b1; op = OP_ANDI;  end
                    F3_SLL:     begin ok = shift_lo_ok; op = OP_SLLI; end
                    default: begin
                        if (shift_lo_ok) begin
                            ok = 1'b1;
                            op = OP_SRLI;
                        end else if (shift_ar_ok) begin
                            ok = 1'b1;
                            op = OP_SRAI;
                        end
                    end
                endcase
            end
            OPC_LOAD: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                imm32   = {{20{instr[31]}}, instr[31:20]};
                case (funct3)
                    3'h0: begin ok = 1'b1; op = OP_LB;  end
                    3'h1: begin ok = 1'b1; op = OP_LH;  end
                    3'h2: begin ok = 1'b1; op = OP_LW;  end
                    3'h3: begin ok = (XLEN == 64); op = OP_LD; end
                    3'h4: begin ok = 1'b1; op = OP_LBU; end
                    3'h5: begin ok = 1'b1; op = OP_LHU; end
                    default: ok = 1'b0;
                endcase
            end
            OPC_STORE: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                case (funct3)
                    3'h0: begin ok = 1'b1; op = OP_SB; end
                    3'h1: begin ok = 1'b1; op = OP_SH; end
                    3'h2: begin ok = 1'b1; op = OP_SW; end
                    default: ok = 1'b0;
                endcase
            end
            OPC_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm32   = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
                case (funct3)
                    3'h0: begin ok = 1'b1; op = OP_BEQ;  end
                    3'h1: begin ok = 1'b1; op = OP_BNE;  end
                    3'h4: begin ok = 1'b1; op = OP_BLT;  end
                    3'h5: begin ok = 1'b1; op = OP_BGE;  end
                    3'h6: begin ok = 1'b1; op = OP_BLTU; end
                    3'h7: begin ok = 1'b1; op = OP_BGEU; end
                    default: ok = 1'b0;
                endcase
            end
            OPC_JAL: begin
                ok     = 1'b1;
                op     = OP_JAL;
                use_rd = 1'b1;
                imm32  = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OPC_JALR: begin
                ok      = (funct3 == 3'h0);
                op      = OP_JALR;
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                imm32   = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_LUI: begin
                ok     = 1'b1;
                op     = OP_LUI;
                use_rd = 1'b1;
                imm32  = {instr[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                ok     = 1'b1;
                op     = OP_AUIPC;
                use_rd = 1'b1;
                imm32  = {instr[31:12], 12'b0};
            end
            default: ok = 1'b0;
        endcase
    end

    // Illegal words collapse to a clean record: no fields, no immediate.
    always_comb begin
        dec.op      = ok ? op : OP_ILLEGAL;
        dec.rd      = (ok && use_rd)  ? instr[11:7]  : 5'd0;
        dec.rs1     = (ok && use_rs1) ? instr[19:15] : 5'd0;
        dec.rs2     = (ok && use_rs2) ? instr[24:20] : 5'd0;
        dec.rd_we   = ok && use_rd;
        dec.rs1_re  = ok && use_rs1;
        dec.rs2_re  = ok && use_rs2;
        dec.illegal = !ok;
        imm         = ok ? XLEN'($signed(imm32)) : '0;
    end

endmodule

// File: rtl/rv_decode_stage.sv
// Decode stage: decoder at the input feeding a 2-entry skid buffer.
//  state | meaning
//  EMPTY | nothing held, out_valid=0
//  ONE   | output register holds a record
//  FULL  | output and skid registers both hold records, in_ready=0
module rv_decode_stage
    import rv_decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int EN_M = 0,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [5:0]      out_op,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic            out_rd_we,
    output logic            out_rs1_re,
    output logic            out_rs2_re,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal,
    output logic [PC_W-1:0] out_pc
);

    buf_state_e      state_q, state_d;
    logic            in_ready_q;
    dec_t            dec, out_dec_q, skid_dec_q;
    logic [XLEN-1:0] imm, out_imm_q, skid_imm_q;
    logic [PC_W-1:0] out_pc_q, skid_pc_q;
    logic            in_xfer, out_xfer;
    logic            ld_out, ld_skid, skid_to_out;

    rv_decode_comb #(.XLEN(XLEN), .EN_M(EN_M)) u_decode (
        .instr (in_instr),
        .dec   (dec),
        .imm   (imm)
    );

    assign out_valid = (state_q != BUF_EMPTY);
    assign in_ready  = in_ready_q;
    assign in_xfer   = in_valid && in_ready_q;
    assign out_xfer  = out_valid && out_ready;

    // Next-state and register-load steering; flush overrides every transfer.
    always_comb begin
        state_d     = state_q;
        ld_out      = 1'b0;
        ld_skid     = 1'b0;
        skid_to_out = 1'b0;
        case (state_q)
            BUF_EMPTY: begin
                if (in_xfer) begin
                    state_d = BUF_ONE;
                    ld_out  = 1'b1;
                end
            end
            BUF_ONE: begin
                if (in_xfer && out_xfer) begin
                    ld_out = 1'b1;
                end else if (in_xfer) begin
                    state_d = BUF_FULL;
                    ld_skid = 1'b1;
                end else if (out_xfer) begin
                    state_d = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                if (out_xfer) begin
                    state_d     = BUF_ONE;
                    skid_to_out = 1'b1;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
        if (flush) begin
            state_d     = BUF_EMPTY;
            ld_out      = 1'b0;
            ld_skid     = 1'b0;
            skid_to_out = 1'b0;
        end
    end

    // State register; in_ready is precomputed from next state so it stays a pure flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BUF_EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != BUF_FULL);
        end
    end

    // Output and skid record registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_dec_q  <= '0;
            out_imm_q  <= '0;
            out_pc_q   <= '0;
            skid_dec_q <= '0;
            skid_imm_q <= '0;
            skid_pc_q  <= '0;
        end else begin
            if (ld_out) begin
                out_dec_q <= dec;
                out_imm_q <= imm;
                out_pc_q  <= in_pc;
            end else if (skid_to_out) begin
                out_dec_q <= skid_dec_q;
                out_imm_q <= skid_imm_q;
                out_pc_q  <= skid_pc_q;
            end
            if (ld_skid) begin
                skid_dec_q <= dec;
                skid_imm_q <= imm;
                skid_pc_q  <= in_pc;
            end
        end
    end

    assign out_op      = out_dec_q.op;
    assign out_rd      = out_dec_q.rd;
    assign out_rs1     = out_dec_q.rs1;
    assign out_rs2     = out_dec_q.rs2;
    assign out_rd_we   = out_dec_q.rd_we;
    assign out_rs1_re  = out_dec_q.rs1_re;
    assign out_rs2_re  = out_dec_q.rs2_re;
    assign out_illegal = out_dec_q.illegal;
    assign out_imm     = out_imm_q;
    assign out_pc      = out_pc_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Scoreboard bench for rv_decode_stage (XLEN=32, EN_M=1).
module tb_rv_decode_stage;

    localparam int NV = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [5:0]  out_op;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic        out_rd_we, out_rs1_re, out_rs2_re;
    logic [31:0] out_imm;
    logic        out_illegal;
    logic [31:0] out_pc;

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rd_we;
        logic        rs1_re;
        logic        rs2_re;
        logic        illegal;
        logic [31:0] imm;
        logic [31:0] pc;
    } rec_t;

    rec_t        exp_q[$];
    logic [31:0] v_instr[NV];
    rec_t        v_exp[NV];
    int          checks = 0;
    int          errors = 0;
    logic        bp_en = 1'b0;
    int          bp_k = 0;
    logic [7:0]  bp_pat = 8'b1011_0010;
    logic [31:0] pc_next = 32'h0000_1000;

    rv_decode_stage #(.XLEN(32), .EN_M(1), .PC_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op      (out_op),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_rd_we   (out_rd_we),
        .out_rs1_re  (out_rs1_re),
        .out_rs2_re  (out_rs2_re),
        .out_imm     (out_imm),
        .out_illegal (out_illegal),
        .out_pc      (out_pc)
    );

    always #5 clk = ~clk;

    function automatic rec_t mk(input int op, input int rd, input int rs1, input int rs2,
                                input int we, input int r1, input int r2, input int ill,
                                input logic [31:0] imm);
        rec_t r;
        r.op      = 6'(op);
        r.rd      = 5'(rd);
        r.rs1     = 5'(rs1);
        r.rs2     = 5'(rs2);
        r.rd_we   = 1'(we);
        r.rs1_re  = 1'(r1);
        r.rs2_re  = 1'(r2);
        r.illegal = 1'(ill);
        r.imm     = imm;
        r.pc      = '0;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] instr, input rec_t e);
        int   n;
        rec_t r;
        n        = 0;
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc_next;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: instr %h in_ready stuck at %b expected 1", instr, in_ready);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            r    = e;
            r.pc = pc_next;
            exp_q.push_back(r);
            pc_next = pc_next + 32'd4;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d records outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Output pattern generator for randomised-looking backpressure.
    initial forever begin
        @(posedge clk);
        #1;
        if (bp_en) begin
            out_ready = bp_pat[bp_k % 8];
            bp_k++;
        end
    end

    // Monitor: compares each accepted output record against the scoreboard head.
    always @(negedge clk) begin
        rec_t a, e;
        if (rst_n && out_valid && out_ready) begin
            a.op = out_op;       a.rd = out_rd;         a.rs1 = out_rs1;       a.rs2 = out_rs2;
            a.rd_we = out_rd_we; a.rs1_re = out_rs1_re; a.rs2_re = out_rs2_re;
            a.illegal = out_illegal; a.imm = out_imm;   a.pc = out_pc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %h expected none", a);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL record pc=%h: got %h expected %h", e.pc, a, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        v_instr[0]  = 32'hFFF00093; v_exp[0]  = mk(10, 1, 0, 0, 1, 1, 0, 0, 32'hFFFFFFFF); // addi x1,x0,-1
        v_instr[1]  = 32'hFE000EE3; v_exp[1]  = mk(27, 0, 0, 0, 0, 1, 1, 0, 32'hFFFFFFFC); // beq -4
        v_instr[2]  = 32'h022081B3; v_exp[2]  = mk(37, 3, 1, 2, 1, 1, 1, 0, 32'h0);        // mul
        v_instr[3]  = 32'h00000000; v_exp[3]  = mk(63, 0, 0, 0, 0, 0, 0, 1, 32'h0);
        v_instr[4]  = 32'h0000707F; v_exp[4]  = mk(63, 0, 0, 0, 0, 0, 0, 1, 32'h0);
        v_instr[5]  = 32'h40208033; v_exp[5]  = mk(1,  0, 1, 2, 1, 1, 1, 0, 32'h0);        // sub
        v_instr[6]  = 32'h800002B7; v_exp[6]  = mk(35, 5, 0, 0, 1, 0, 0, 0, 32'h80000000); // lui
        v_instr[7]  = 32'h12345297; v_exp[7]  = mk(36, 5, 0, 0, 1, 0, 0, 0, 32'h12345000); // auipc
        v_instr[8]  = 32'h40315093; v_exp[8]  = mk(18, 1, 2, 0, 1, 1, 0, 0, 32'h00000403); // srai
        v_instr[9]  = 32'h40311093; v_exp[9]  = mk(63, 0, 0, 0, 0, 0, 0, 1, 32'h0);        // slli bad f7
        v_instr[10] = 32'hFE20AC23; v_exp[10] = mk(26, 0, 1, 2, 0, 1, 1, 0, 32'hFFFFFFF8); // sw
        v_instr[11] = 32'h008000EF; v_exp[11] = mk(33, 1, 0, 0, 1, 0, 0, 0, 32'h00000008); // jal
        v_instr[12] = 32'h0101A203; v_exp[12] = mk(21, 4, 3, 0, 1, 1, 0, 0, 32'h00000010); // lw
        v_instr[13] = 32'h0101B203; v_exp[13] = mk(63, 0, 0, 0, 0, 0, 0, 1, 32'h0);        // load f3=3
        v_instr[14] = 32'h04208033; v_exp[14] = mk(63, 0, 0, 0, 0, 0, 0, 1, 32'h0);        // bad funct7

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_op",    32'(out_op),    32'd0);
        chk("rst_out_imm",   out_imm,        32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        // All vectors under a fixed backpressure pattern.
        bp_en = 1'b1;
        for (int i = 0; i < NV; i++) send(v_instr[i], v_exp[i]);
        in_valid = 1'b0;
        drain();
        @(negedge clk);
        bp_en     = 1'b0;
        out_ready = 1'b0;

        // Three back-to-back with the output stalled for four cycles.
        @(posedge clk);
        #1;
        fork
            begin
                send(v_instr[0], v_exp[0]);
                send(v_instr[5], v_exp[5]);
                send(v_instr[6], v_exp[6]);
                in_valid = 1'b0;
            end
            begin
                @(posedge clk);
                @(posedge clk);
                #2;
                chk("full_in_ready",  32'(in_ready),  32'd0);
                chk("full_out_valid", 32'(out_valid), 32'd1);
                repeat (4) @(posedge clk);
                #2;
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                out_ready = 1'b1;
            end
        join
        drain();

        // Flush while FULL.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(v_instr[1], v_exp[1]);
        send(v_instr[2], v_exp[2]);
        in_instr = v_instr[3];
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        chk("flush_full_out_valid", 32'(out_valid), 32'd0);
        chk("flush_full_in_ready",  32'(in_ready),  32'd1);

        // Flush in ONE with a simultaneous input transfer: both discarded.
        send(v_instr[8], v_exp[8]);
        in_valid = 1'b1;
        in_instr = v_instr[10];
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        chk("flush_one_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        send(v_instr[12], v_exp[12]);
        in_valid = 1'b0;
        drain();

        // Asynchronous reset mid-stream.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(v_instr[1], v_exp[1]);
        in_valid = 1'b0;
        #3;
        chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_in_ready",  32'(in_ready),  32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_rerst",  32'(in_ready),  32'd1);
        chk("out_valid_after_rerst", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        send(v_instr[7], v_exp[7]);
        in_valid = 1'b0;
        drain();

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_decode_stage.md
RV_DECODE_STAGE -- requirements
Module: rv_decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath and immediate width (legal values 32, 64).
REQ-002 SHALL have parameter EN_M, default 0, meaning enable decode of RV32M ops (MUL..REMU).
REQ-003 SHALL have parameter PC_W, default 32, meaning width of the PC sideband carried with each instruction.
REQ-004 clk  input  1  rising-edge clock; the block has one clock; reset is asynchronous and active-low.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 flush  input  1  synchronous discard of all held instructions.
REQ-007 in_valid  input  1  upstream instruction valid.
REQ-008 in_ready  output  1  block can accept; registered.
REQ-009 in_instr  input  32  raw instruction word.
REQ-010 in_pc  input  PC_W  instruction address sideband.
REQ-011 out_valid  output  1  decoded record valid.
REQ-012 out_ready  input  1  downstream accepts.
REQ-013 out_op  output  6  operation id (package enum; OP_ILLEGAL = 63).
REQ-014 out_rd, out_rs1, out_rs2  output  5 each  register indices; forced to 0 when the field is unused.
REQ-015 out_rd_we, out_rs1_re, out_rs2_re  output  1 each  field-valid flags.
REQ-016 out_imm  output  XLEN  sign-extended immediate; 0 for R-type.
REQ-017 out_illegal  output  1  undecodable instruction.
REQ-018 out_pc  output  PC_W  in_pc of the presented record.

Function
REQ-019 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-020 Latency SHALL be 1 cycle: an instruction accepted at edge N is presented with out_valid=1 after edge N.
REQ-021 The block SHALL hold decoded records in a 2-entry skid buffer with states EMPTY (0 held), ONE (output reg held), FULL (output + skid reg held).
REQ-022 Transitions: EMPTY->ONE on in-xfer; ONE->EMPTY on out-xfer without in-xfer; ONE->FULL on in-xfer without out-xfer; FULL->ONE on out-xfer, with the skid entry moving to the output reg; all other combinations hold state.
REQ-023 in_ready SHALL be 1 in EMPTY and ONE, and 0 in FULL; it SHALL be a flop with no combinational path from out_ready.
REQ-024 Order SHALL be preserved; no record is dropped or duplicated under any out_ready pattern.
REQ-025 Decode SHALL occur on the input side, before the register, so that out_* are registered values.
REQ-026 Immediates SHALL be sign-extended to XLEN from instr[31] for I, S, B and J types; U-type SHALL be {instr[31:12],12'b0}, sign-extended.
REQ-027 The opcode compare SHALL be exact: LUI 0110111 and AUIPC 0010111 are distinct ops, with no wildcard compare.
REQ-028 SLLI/SRLI SHALL require funct7=0000000 and SRAI SHALL require funct7=0100000 (XLEN=64: funct6 with shamt[5]); any other value -> illegal.
REQ-029 R-type SHALL require funct7 = 0000000 or 0100000 (SUB, SRA only), or 0000001 when EN_M=1; any other value -> illegal.
REQ-030 Unknown opcode, unsupported funct3 (loads 3'h3 (XLEN=32), 6 and 7; stores >2; branch 2 or 3), instr[1:0]!=2'b11, or the all-zero word SHALL give out_illegal=1, out_op=OP_ILLEGAL and all valid flags 0.
REQ-031 An illegal instruction SHALL still flow through the handshake normally.
REQ-032 flush SHALL force state to EMPTY at the next edge and drop both entries; an in-xfer in the same cycle is discarded.
REQ-033 flush SHALL have priority over all simultaneous transfers.

Reset
REQ-034 While rst_n=0: state=EMPTY, out_valid=0, in_ready=0, all out_* data=0, out_op=0.
REQ-035 in_ready SHALL rise on the first clk edge after reset deassertion.
REQ-036 Reset asserted mid-operation SHALL discard held records immediately (asynchronously).

Structure
REQ-037 Package rv_decode_pkg SHALL hold the opcode localparams, the op enum (ADD=0..AUIPC=36, MUL..REMU=37..44, OP_ILLEGAL=63), the funct3/funct7 constants and the decoded-record struct.
REQ-038 The block SHALL contain one combinational sub-module, rv_decode_comb (instr -> record), instantiated once at the input.

Verification
REQ-039 Stimulus 0xFFF00093 (addi x1,x0,-1) -> op=ADDI, rd=1, rs1=0, rd_we=1, rs2_re=0, imm=0xFFFFFFFF, one cycle later.
REQ-040 Stimulus 0xFE000EE3 (beq x0,x0,-4) -> op=BEQ, imm=0xFFFFFFFC, rd_we=0, rs1_re=1, rs2_re=1.
REQ-041 Stimulus 0x022081B3 (mul x3,x1,x2) -> EN_M=1: op=MUL, rd=3, rs1=1, rs2=2; EN_M=0: illegal=1, op=63.
REQ-042 Stimulus 0x00000000 and 0x0000707F -> illegal=1, handshake completes, next valid instruction decodes normally.
REQ-043 Stimulus: 3 back-to-back instructions with out_ready=0 for 4 cycles -> in_ready=0 after 2 accepts; then out_ready=1 -> all 3 emerge in order.
REQ-044 Stimulus: flush in FULL state -> out_valid=0 next cycle; rst_n pulse mid-stream -> out_valid drops immediately and in_ready=1 one edge after release.
